// File: rtl/jtdd_subcom_pkg.sv
// jtdd_subcom_pkg
// Shared definitions for the main/sub CPU communication block:
//   - hs_state_e : bus-request handshake FSM encoding (IDLE, REQ, HELD, TMO)
//   - STAT_*     : bit positions inside the 3-bit status word {timeout, drop, held}
package jtdd_subcom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HELD = 2'd2,
        ST_TMO  = 2'd3
    } hs_state_e;

    localparam int STAT_W    = 3;
    localparam int STAT_HELD = 0;
    localparam int STAT_DROP = 1;
    localparam int STAT_TMO  = 2;

endpackage

// File: rtl/jtdd_subcom_latch.sv
// jtdd_subcom_latch
// Generic registered set/clear flag with set priority, used for the NMI
// latch towards the sub CPU and the IRQ latch towards the main CPU.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset (flag clears)
//   set_i     : sets the flag on the next clock (wins over clr_i)
//   clr_i     : clears the flag on the next clock
//   q_o       : registered flag
module jtdd_subcom_latch (
    input  logic clk,
    input  logic rstn,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);

    logic flag_q;

    // Set has priority so an event arriving together with its acknowledge
    // is never lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            flag_q <= 1'b0;
        else if (set_i)
            flag_q <= 1'b1;
        else if (clr_i)
            flag_q <= 1'b0;
    end

    assign q_o = flag_q;

endmodule

// File: rtl/jtdd_subcom.sv
// jtdd_subcom
// Main/sub CPU communication block: shared dual-port RAM, bus-request
// handshake with grant timeout, NMI latch to the sub CPU, IRQ latch to the
// main CPU and a sticky status word {timeout, drop, held}.
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   main_cen/AB/wrn/dout, com_cs    : main CPU bus into the shared window
//   shared_dout                     : RAM read data, main port (1 clk latency)
//   mcu_halt, sub_busak_n           : halt request in, bus acknowledge from sub
//   sub_busrq_n                     : registered bus request to sub CPU
//   mcu_nmi_set, sub_nmi_ack        : NMI raise (rising edge) / acknowledge
//   sub_nmi_n                       : NMI to sub CPU
//   sub_irq_set, irq_ack            : IRQ-to-main raise / acknowledge
//   mcu_irqmain                     : IRQ to main CPU
//   sub_cen/A/cs/wrn/dout, sub_din  : sub CPU bus into the shared RAM
//   status, status_clr              : {timeout, drop, held}, clear of sticky bits
// Optional feature macro: JTDD_SUBCOM_WRGUARD_EN
//   defined     -> main writes accepted only while HELD, others set drop
//   not defined -> main writes accepted in any state, drop stays 0
module jtdd_subcom
    import jtdd_subcom_pkg::*;
#(
    parameter int AW       = 10,
    parameter int MAW      = 9,
    parameter int MOFS     = 0,
    parameter int TOUT     = 255,
    parameter     DUMPFILE = "sub.hex"
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           main_cen,
    input  logic [MAW-1:0] main_AB,
    input  logic           main_wrn,
    input  logic [7:0]     main_dout,
    input  logic           com_cs,
    output logic [7:0]     shared_dout,
    input  logic           mcu_halt,
    input  logic           mcu_nmi_set,
    input  logic           irq_ack,
    input  logic           sub_cen,
    input  logic [AW-1:0]  sub_A,
    input  logic           sub_cs,
    input  logic           sub_wrn,
    input  logic [7:0]     sub_dout,
    output logic [7:0]     sub_din,
    input  logic           sub_nmi_ack,
    input  logic           sub_irq_set,
    input  logic           sub_busak_n,
    output logic           sub_busrq_n,
    output logic           sub_nmi_n,
    output logic           mcu_irqmain,
    output logic [2:0]     status,
    input  logic           status_clr
);

    localparam logic [7:0]    ToutLast = 8'(TOUT - 1);
    localparam logic [AW-1:0] MainOfs  = AW'(MOFS);

    hs_state_e     state_q;
    logic [7:0]    tmoCnt_q;
    logic          busrqN_q;
    logic          held_q;
    logic          tmo_q;
    logic          drop_q;

    logic          comCs_q;
    logic          mainWrn_q;
    logic [AW-1:0] mainAddr_q;
    logic          mainWe_q;
    logic [7:0]    mainData_q;

    logic          subWe_q;
    logic [AW-1:0] subAddr_q;
    logic [7:0]    subData_q;

    logic          nmiSetIn_q;
    logic          nmiLatch;

    logic [7:0]    mem [2**AW];
    logic [7:0]    mainRd_q;
    logic [7:0]    subRd_q;

    logic          mainWrReq;
    logic          mainWrOk;
    logic          mainWrDrop;

    // Handshake FSM. Outputs are computed from the next state so busrq and
    // held change on the same edge as the state. Release of the halt request
    // always has priority over grant/timeout events.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            tmoCnt_q <= '0;
            busrqN_q <= 1'b1;
            held_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (status_clr)
                tmo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mcu_halt) begin
                        state_q  <= ST_REQ;
                        tmoCnt_q <= '0;
                        busrqN_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!mcu_halt) begin
                        state_q  <= ST_IDLE;
                        busrqN_q <= 1'b1;
                    end else if (!sub_busak_n) begin
                        state_q <= ST_HELD;
                        held_q  <= 1'b1;
                    end else if (tmoCnt_q == ToutLast) begin
                        state_q <= ST_TMO;
                        tmo_q   <= 1'b1;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (!mcu_halt) begin
                        state_q  <= ST_IDLE;
                        busrqN_q <= 1'b1;
                        held_q   <= 1'b0;
                    end else if (sub_busak_n) begin
                        state_q  <= ST_REQ;
                        tmoCnt_q <= '0;
                        held_q   <= 1'b0;
                    end
                end
                ST_TMO: begin
                    if (!mcu_halt) begin
                        state_q  <= ST_IDLE;
                        busrqN_q <= 1'b1;
                    end else if (!sub_busak_n) begin
                        state_q <= ST_HELD;
                        held_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busrqN_q <= 1'b1;
                    held_q   <= 1'b0;
                end
            endcase
        end
    end

    // A main write request is a falling wrn edge while the window is selected
    // and the main CPU is enabled.
    assign mainWrReq = mainWrn_q & ~main_wrn & com_cs & main_cen;

`ifdef JTDD_SUBCOM_WRGUARD_EN
    assign mainWrOk   = mainWrReq & (state_q == ST_HELD);
    assign mainWrDrop = mainWrReq & (state_q != ST_HELD);
`else
    assign mainWrOk   = mainWrReq;
    assign mainWrDrop = 1'b0;
`endif

    // Main port: edge detectors, offset address latch and the one-clk write
    // pulse. The offset addition wraps naturally at AW bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            comCs_q    <= 1'b0;
            mainWrn_q  <= 1'b1;
            mainAddr_q <= '0;
            mainWe_q   <= 1'b0;
            mainData_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            comCs_q   <= com_cs;
            mainWrn_q <= main_wrn;
            mainWe_q  <= mainWrOk;
            if (com_cs && !comCs_q)
                mainAddr_q <= AW'(main_AB) + MainOfs;
            if (mainWrOk)
                mainData_q <= main_dout;
            if (mainWrDrop)
                drop_q <= 1'b1;
            else if (status_clr)
                drop_q <= 1'b0;
        end
    end

    // Sub port write pulse plus the NMI request edge detector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            subWe_q    <= 1'b0;
            subAddr_q  <= '0;
            subData_q  <= '0;
            nmiSetIn_q <= 1'b0;
        end else begin
            subWe_q    <= ~sub_wrn & sub_cs & sub_cen;
            subAddr_q  <= sub_A;
            subData_q  <= sub_dout;
            nmiSetIn_q <= mcu_nmi_set;
        end
    end

    // Shared RAM. The main write is issued last so it wins a same-address
    // collision. Reads are registered and return the pre-write contents.
    always_ff @(posedge clk) begin
        if (subWe_q)
            mem[subAddr_q] <= subData_q;
        if (mainWe_q)
            mem[mainAddr_q] <= mainData_q;
        mainRd_q <= mem[mainAddr_q];
        subRd_q  <= mem[sub_A];
    end

    jtdd_subcom_latch u_nmi (
        .clk   (clk),
        .rstn  (rstn),
        .set_i (mcu_nmi_set & ~nmiSetIn_q),
        .clr_i (sub_nmi_ack),
        .q_o   (nmiLatch)
    );

    jtdd_subcom_latch u_irq (
        .clk   (clk),
        .rstn  (rstn),
        .set_i (sub_irq_set & sub_cen),
        .clr_i (irq_ack),
        .q_o   (mcu_irqmain)
    );

    always_comb begin
        status            = '0;
        status[STAT_HELD] = held_q;
        status[STAT_DROP] = drop_q;
        status[STAT_TMO]  = tmo_q;
    end

    assign sub_busrq_n = busrqN_q;
    assign sub_nmi_n   = ~nmiLatch;
    assign shared_dout = mainRd_q;
    assign sub_din     = subRd_q;

endmodule

// File: tb/tb_jtdd_subcom.sv
// tb_jtdd_subcom
// Directed test of jtdd_subcom with AW=10, MAW=9, MOFS=0x100, TOUT=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jtdd_subcom;

    logic       clk = 1'b0;
    logic       rstn;
    logic       main_cen, main_wrn, com_cs;
    logic [8:0] main_AB;
    logic [7:0] main_dout, shared_dout;
    logic       mcu_halt, mcu_nmi_set, irq_ack;
    logic       sub_cen, sub_cs, sub_wrn;
    logic [9:0] sub_A;
    logic [7:0] sub_dout, sub_din;
    logic       sub_nmi_ack, sub_irq_set, sub_busak_n;
    logic       sub_busrq_n, sub_nmi_n, mcu_irqmain;
    logic [2:0] status;
    logic       status_clr;

    int checkCount = 0;
    int passCount  = 0;
    logic [2:0] expDrop;

    always #5 clk = ~clk;

    jtdd_subcom #(
        .AW(10), .MAW(9), .MOFS(256), .TOUT(16), .DUMPFILE("sub.hex")
    ) dut (
        .clk(clk), .rstn(rstn),
        .main_cen(main_cen), .main_AB(main_AB), .main_wrn(main_wrn),
        .main_dout(main_dout), .com_cs(com_cs), .shared_dout(shared_dout),
        .mcu_halt(mcu_halt), .mcu_nmi_set(mcu_nmi_set), .irq_ack(irq_ack),
        .sub_cen(sub_cen), .sub_A(sub_A), .sub_cs(sub_cs), .sub_wrn(sub_wrn),
        .sub_dout(sub_dout), .sub_din(sub_din), .sub_nmi_ack(sub_nmi_ack),
        .sub_irq_set(sub_irq_set), .sub_busak_n(sub_busak_n),
        .sub_busrq_n(sub_busrq_n), .sub_nmi_n(sub_nmi_n),
        .mcu_irqmain(mcu_irqmain), .status(status), .status_clr(status_clr)
    );

    // Counts every comparison and reports any mismatch on a single line.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advances n clocks, leaving time at a falling edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Main-side write through the window: select, wrn falling edge, release.
    // Returns one clock after the write pulse has landed.
    task automatic mainWrite(input logic [8:0] addr, input logic [7:0] data);
        com_cs = 1'b1; main_AB = addr; main_wrn = 1'b1;
        applyStimulus(1);
        main_wrn = 1'b0; main_dout = data;
        applyStimulus(1);
        main_wrn = 1'b1; com_cs = 1'b0;
        applyStimulus(1);
    endtask

    task automatic subRead(input logic [9:0] addr, output logic [7:0] data);
        sub_A = addr;
        applyStimulus(1);
        data = sub_din;
    endtask

    // Safety net in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        rstn = 1'b0;
        main_cen = 1'b1; main_wrn = 1'b1; com_cs = 1'b0; main_AB = '0; main_dout = '0;
        mcu_halt = 1'b0; mcu_nmi_set = 1'b0; irq_ack = 1'b0;
        sub_cen = 1'b1; sub_cs = 1'b0; sub_wrn = 1'b1; sub_A = '0; sub_dout = '0;
        sub_nmi_ack = 1'b0; sub_irq_set = 1'b0; sub_busak_n = 1'b1; status_clr = 1'b0;
        applyStimulus(2);
        checkOutput("reset_busrq_n", 32'(sub_busrq_n), 32'd1);
        checkOutput("reset_nmi_n",   32'(sub_nmi_n),   32'd1);
        checkOutput("reset_irqmain", 32'(mcu_irqmain), 32'd0);
        checkOutput("reset_status",  32'(status),      32'd0);
        rstn = 1'b1;
        applyStimulus(1);

        // Handshake: busrq drops after 1 clk, grant 3 clk later, held at +4.
        mcu_halt = 1'b1;
        applyStimulus(1);
        checkOutput("hs_busrq_low", 32'(sub_busrq_n), 32'd0);
        checkOutput("hs_not_held",  32'(status),      32'd0);
        applyStimulus(2);
        sub_busak_n = 1'b0;
        applyStimulus(1);
        checkOutput("hs_held", 32'(status), 32'b001);

        // Write while HELD: 0x013 + 0x100 = 0x113.
        mainWrite(9'h013, 8'h5A);
        subRead(10'h113, rd);
        checkOutput("held_write_sub",  32'(rd),          32'h5A);
        checkOutput("held_write_main", 32'(shared_dout), 32'h5A);

        // Release the halt request.
        mcu_halt = 1'b0; sub_busak_n = 1'b1;
        applyStimulus(1);
        checkOutput("rel_busrq_high", 32'(sub_busrq_n), 32'd1);
        checkOutput("rel_status",     32'(status),      32'd0);

        // Same write in IDLE: dropped only with the write guard.
        mainWrite(9'h013, 8'hA5);
        subRead(10'h113, rd);
`ifdef JTDD_SUBCOM_WRGUARD_EN
        checkOutput("idle_write_data", 32'(rd), 32'h5A);
        expDrop = 3'b010;
`else
        checkOutput("idle_write_data", 32'(rd), 32'hA5);
        expDrop = 3'b000;
`endif
        checkOutput("idle_drop", 32'(status), 32'(expDrop));
        status_clr = 1'b1;
        applyStimulus(1);
        status_clr = 1'b0;
        checkOutput("drop_cleared", 32'(status), 32'd0);

        // Timeout: REQ entered 1 clk after halt, timeout 16 clk later.
        mcu_halt = 1'b1;
        applyStimulus(16);
        checkOutput("tmo_not_yet", 32'(status), 32'd0);
        applyStimulus(1);
        checkOutput("tmo_set",   32'(status),      32'b100);
        checkOutput("tmo_busrq", 32'(sub_busrq_n), 32'd0);
        sub_busak_n = 1'b0;
        applyStimulus(1);
        checkOutput("tmo_to_held", 32'(status), 32'b101);
        status_clr = 1'b1;
        applyStimulus(1);
        status_clr = 1'b0;
        checkOutput("tmo_cleared", 32'(status), 32'b001);

        // Collision: main 0x11 and sub 0x22 to 0x120 in the same clock.
        com_cs = 1'b1; main_AB = 9'h020;
        applyStimulus(1);
        main_wrn = 1'b0; main_dout = 8'h11;
        sub_A = 10'h120; sub_dout = 8'h22; sub_wrn = 1'b0; sub_cs = 1'b1;
        applyStimulus(1);
        main_wrn = 1'b1; com_cs = 1'b0; sub_wrn = 1'b1; sub_cs = 1'b0;
        applyStimulus(2);
        checkOutput("collision_sub",  32'(sub_din),     32'h11);
        checkOutput("collision_main", 32'(shared_dout), 32'h11);

        // Sub-only write and read back.
        sub_A = 10'h055; sub_dout = 8'h33; sub_wrn = 1'b0; sub_cs = 1'b1;
        applyStimulus(1);
        sub_wrn = 1'b1; sub_cs = 1'b0;
        applyStimulus(2);
        checkOutput("sub_write", 32'(sub_din), 32'h33);

        // IRQ latch: set, set+ack (set wins), ack alone clears.
        sub_irq_set = 1'b1;
        applyStimulus(1);
        checkOutput("irq_set", 32'(mcu_irqmain), 32'd1);
        irq_ack = 1'b1;
        applyStimulus(1);
        checkOutput("irq_set_wins", 32'(mcu_irqmain), 32'd1);
        sub_irq_set = 1'b0;
        applyStimulus(1);
        irq_ack = 1'b0;
        checkOutput("irq_cleared", 32'(mcu_irqmain), 32'd0);

        // NMI latch: edge together with ack sets; ack alone clears; a held
        // level does not set it again.
        mcu_nmi_set = 1'b1; sub_nmi_ack = 1'b1;
        applyStimulus(1);
        checkOutput("nmi_set_wins", 32'(sub_nmi_n), 32'd0);
        sub_nmi_ack = 1'b0;
        applyStimulus(1);
        checkOutput("nmi_holds", 32'(sub_nmi_n), 32'd0);
        sub_nmi_ack = 1'b1;
        applyStimulus(1);
        sub_nmi_ack = 1'b0;
        checkOutput("nmi_cleared", 32'(sub_nmi_n), 32'd1);
        applyStimulus(1);
        checkOutput("nmi_level_no_reset", 32'(sub_nmi_n), 32'd1);
        mcu_nmi_set = 1'b0;

        // Asynchronous reset while HELD with the IRQ raised.
        sub_irq_set = 1'b1;
        applyStimulus(1);
        sub_irq_set = 1'b0;
        checkOutput("pre_rst_status", 32'(status),      32'b001);
        checkOutput("pre_rst_irq",    32'(mcu_irqmain), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_busrq",  32'(sub_busrq_n), 32'd1);
        checkOutput("async_rst_status", 32'(status),      32'd0);
        checkOutput("async_rst_irq",    32'(mcu_irqmain), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
